addsub_result_buffer: RTL and testbench

//  Registered result stage directly downstream of the 4-bit add/subtract unit.
//  - Captures each {sum, carry/borrow, op} result through a valid/ready handshake into a small FIFO.
//  - Derives a zero flag per result.
//  - Keeps a saturating count of results that produced carry/borrow.
//  - Decouples the combinational adder from slower consumers (display/register file).

---
 rtl/addsub_result_buffer.sv | 55 +++++
 tb/tb_addsub_result_buffer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/addsub_result_buffer.sv
// addsub_result_buffer: registered FIFO stage for add/subtract results with zero flag and carry/borrow event count
// Ports: clk/rst (sync, active-high); in_* valid/ready upstream result {sum, cout, sub};
// out_* valid/ready head entry plus stored zero flag; carry_cnt saturating counter, clr_cnt clears it.
module addsub_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_sum,
  input  logic             in_cout,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_sub,
  output logic             out_zero,
  output logic [CNT_W-1:0] carry_cnt,
  input  logic             clr_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH+2:0] mem [DEPTH];
  logic [WIDTH+2:0] head;
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic [AW:0]      count;
  logic             push, pop, empty;
  // DEPTH is a power of two, so the occupancy MSB alone marks full
  assign empty     = count == '0;
  assign in_ready  = !count[AW] & !rst;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign head      = empty ? '0 : mem[rd_ptr];
  assign {out_zero, out_sub, out_cout, out_sum} = head;
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      carry_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) mem[wr_ptr] <= {~|in_sum, in_sub, in_cout, in_sum};
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push != pop) count <= push ? count + (AW+1)'(1) : count - (AW+1)'(1);
      if (clr_cnt) carry_cnt <= '0;
      else if (push & in_cout & ~&carry_cnt) carry_cnt <= carry_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_addsub_result_buffer.sv
// tb_addsub_result_buffer: directed table plus randomized queue-model check of addsub_result_buffer
module tb_addsub_result_buffer;
  logic clk = 1'b0;
  logic rst, in_valid, in_cout, in_sub, out_ready, clr_cnt;
  logic [3:0] in_sum;
  logic in_ready, out_valid, out_cout, out_sub, out_zero;
  logic [3:0] out_sum;
  logic [7:0] carry_cnt;
  logic in_ready2, out_valid2, out_cout2, out_sub2, out_zero2;
  logic [3:0] out_sum2;
  logic [1:0] carry_cnt2;

  addsub_result_buffer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum),
    .in_cout(in_cout), .in_sub(in_sub), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_sub(out_sub), .out_zero(out_zero),
    .carry_cnt(carry_cnt), .clr_cnt(clr_cnt));

  addsub_result_buffer #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_sum(in_sum),
    .in_cout(in_cout), .in_sub(in_sub), .out_valid(out_valid2), .out_ready(out_ready),
    .out_sum(out_sum2), .out_cout(out_cout2), .out_sub(out_sub2), .out_zero(out_zero2),
    .carry_cnt(carry_cnt2), .clr_cnt(clr_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit r, iv; bit [3:0] s; bit co, sb, ordy, clr;
    bit ir, ov; bit [3:0] os; bit oco, osb, oz; bit [7:0] c8; bit [1:0] c2;
  } vec_t;

  typedef struct { bit [3:0] s; bit c, b; } ent_t;

  int vectors = 0, miscompares = 0;
  vec_t tbl[18];
  ent_t q[$];
  int m_c8, m_c2;

  function automatic vec_t v(bit r, bit iv, bit [3:0] s, bit co, bit sb, bit ordy, bit clr,
                             bit ir, bit ov, bit [3:0] os, bit oco, bit osb, bit oz,
                             bit [7:0] c8, bit [1:0] c2);
    vec_t t;
    t.r = r; t.iv = iv; t.s = s; t.co = co; t.sb = sb; t.ordy = ordy; t.clr = clr;
    t.ir = ir; t.ov = ov; t.os = os; t.oco = oco; t.osb = osb; t.oz = oz; t.c8 = c8; t.c2 = c2;
    return t;
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic check_head(string p, bit ov, bit [3:0] s, bit co, bit sb, bit z, int c8, int c2);
    chk({p, ".out_valid"}, out_valid, ov);
    chk({p, ".out_sum"}, out_sum, s);
    chk({p, ".out_cout"}, out_cout, co);
    chk({p, ".out_sub"}, out_sub, sb);
    chk({p, ".out_zero"}, out_zero, z);
    chk({p, ".carry_cnt8"}, carry_cnt, c8);
    chk({p, ".carry_cnt2"}, carry_cnt2, c2);
  endtask

  initial begin
    rst = 1; in_valid = 0; in_sum = 0; in_cout = 0; in_sub = 0; out_ready = 0; clr_cnt = 0;
    //            r iv  s co sb or cl | ir ov os co sb z c8 c2
    tbl[0]  = v(1, 0,  0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = v(0, 1,  5, 0, 0, 0, 0,   1, 1, 5, 0, 0, 0, 0, 0);
    tbl[2]  = v(0, 1,  9, 0, 1, 0, 0,   0, 1, 5, 0, 0, 0, 0, 0);
    tbl[3]  = v(0, 1,  3, 0, 0, 0, 0,   0, 1, 5, 0, 0, 0, 0, 0);
    tbl[4]  = v(0, 1,  3, 0, 0, 1, 0,   1, 1, 9, 0, 1, 0, 0, 0);
    tbl[5]  = v(0, 1,  3, 0, 0, 1, 0,   1, 1, 3, 0, 0, 0, 0, 0);
    tbl[6]  = v(0, 0,  0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = v(0, 1, 10, 0, 0, 0, 0,   1, 1,10, 0, 0, 0, 0, 0);
    tbl[8]  = v(0, 1,  0, 1, 1, 1, 0,   1, 1, 0, 1, 1, 1, 1, 1);
    tbl[9]  = v(0, 1,  1, 1, 0, 1, 0,   1, 1, 1, 1, 0, 0, 2, 2);
    tbl[10] = v(0, 1,  2, 1, 0, 1, 0,   1, 1, 2, 1, 0, 0, 3, 3);
    tbl[11] = v(0, 1,  3, 1, 0, 1, 0,   1, 1, 3, 1, 0, 0, 4, 3);
    tbl[12] = v(0, 1,  4, 1, 0, 1, 0,   1, 1, 4, 1, 0, 0, 5, 3);
    tbl[13] = v(0, 1,  5, 1, 0, 1, 1,   1, 1, 5, 1, 0, 0, 0, 0);
    tbl[14] = v(0, 1,  6, 0, 0, 0, 0,   0, 1, 5, 1, 0, 0, 0, 0);
    tbl[15] = v(1, 1,  7, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    tbl[16] = v(0, 0,  0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    tbl[17] = v(0, 0,  0, 0, 0, 1, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      rst = tbl[i].r; in_valid = tbl[i].iv; in_sum = tbl[i].s; in_cout = tbl[i].co;
      in_sub = tbl[i].sb; out_ready = tbl[i].ordy; clr_cnt = tbl[i].clr;
      @(posedge clk);
      #1;
      chk($sformatf("dir%0d.in_ready", i), in_ready, tbl[i].ir);
      check_head($sformatf("dir%0d", i), tbl[i].ov, tbl[i].os, tbl[i].oco, tbl[i].osb, tbl[i].oz,
                 tbl[i].c8, tbl[i].c2);
    end
    q.delete();
    m_c8 = 0;
    m_c2 = 0;
    for (int n = 0; n < 10000; n++) begin
      bit full, push, pop;
      @(negedge clk);
      rst = $urandom_range(0, 499) == 0;
      in_valid = $urandom_range(0, 2) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_sum = 4'($urandom_range(0, 15));
      in_cout = $urandom_range(0, 1) == 1;
      in_sub = $urandom_range(0, 1) == 1;
      clr_cnt = $urandom_range(0, 63) == 0;
      full = q.size() == 2;
      #1;
      chk("rnd.in_ready_pre", in_ready, !full && !rst);
      push = !rst && in_valid && !full;
      pop = !rst && out_ready && q.size() > 0;
      if (rst) begin
        q.delete();
        m_c8 = 0;
        m_c2 = 0;
      end else begin
        if (pop) void'(q.pop_front());
        if (push) q.push_back('{in_sum, in_cout, in_sub});
        if (clr_cnt) begin
          m_c8 = 0;
          m_c2 = 0;
        end else if (push && in_cout) begin
          m_c8 = m_c8 < 255 ? m_c8 + 1 : 255;
          m_c2 = m_c2 < 3 ? m_c2 + 1 : 3;
        end
      end
      @(posedge clk);
      #1;
      if (q.size() > 0)
        check_head("rnd", 1, q[0].s, q[0].c, q[0].b, q[0].s == 0, m_c8, m_c2);
      else
        check_head("rnd", 0, 0, 0, 0, 0, m_c8, m_c2);
      chk("rnd.zero_flag", out_zero, out_valid && out_sum == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
